// File: rtl/resp_arb_pkg.sv
// Shared types and constants for the UART response-channel arbiter.
package resp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } state_e;

   localparam logic OWN_CC  = 1'b0;
   localparam logic OWN_RAM = 1'b1;

   localparam int TO_CYC_DEF = 65535;

   typedef struct packed {
      logic       pend;
      logic       last;
      logic [7:0] dat;
   } slot_t;

endpackage

// File: rtl/resp_slot.sv
// One-entry holding register for a byte producer.
// Latency: req at n -> pend visible at n+1.
// Backpressure: none upstream; a req while full is dropped and flagged on ovf.
module resp_slot
   import resp_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [7:0] req_dat,
   input  logic       req_last,
   input  logic       clr,
   output logic       pend,
   output logic [7:0] dat,
   output logic       last,
   output logic       ovf
);

   slot_t slot_q;
   logic  load;

   // A reload in the launch cycle replaces the byte being consumed, so it wins over clr.
   assign load = req && (!slot_q.pend || clr);
   assign ovf  = req && slot_q.pend && !clr;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
      end else if (load) begin
         slot_q <= '{pend: 1'b1, last: req_last, dat: req_dat};
      end else if (clr) begin
         slot_q.pend <= 1'b0;
      end
   end

   assign pend = slot_q.pend;
   assign dat  = slot_q.dat;
   assign last = slot_q.last;

endmodule

// File: rtl/resp_arb.sv
// Shares the UART response channel between cc responses and the RAM dump stream.
// Latency: req at n -> trmt at n+2 when idle; tx_done at m -> done at m+1, next trmt >= m+2.
// Backpressure: producers are never stalled; each has one slot, extra reqs set ovf_err.
module resp_arb
   import resp_arb_pkg::*;
#(
   parameter int TO_CYC = TO_CYC_DEF
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cc_req,
   input  logic [7:0] cc_data,
   output logic       cc_done,
   input  logic       ram_req,
   input  logic [7:0] ram_data,
   input  logic       ram_last,
   output logic       ram_done,
   output logic       trmt,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic       ovf_err,
   output logic       to_err,
   input  logic       err_clr
);

   localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

   state_e      state;
   logic        own;
   logic        lock;
   logic        cur_last;
   logic [15:0] cnt;

   logic       cc_pend, ram_pend;
   logic [7:0] cc_dat, ram_dat;
   logic       cc_last, ram_last_q;
   logic       cc_ovf, ram_ovf;

   logic launch, cc_clr, ram_clr;
   logic pick_cc, pick_ram;
   logic done_fire, to_fire;

   assign launch   = (state == LAUNCH);
   assign cc_clr   = launch && (own == OWN_CC);
   assign ram_clr  = launch && (own == OWN_RAM);

   // While a dump burst holds the lock only the ram slot may be chosen.
   assign pick_cc  = (state == IDLE) && cc_pend && !lock;
   assign pick_ram = (state == IDLE) && ram_pend && (lock || !cc_pend);

   assign done_fire = (state == WAIT) && tx_done;
   assign to_fire   = (state == WAIT) && !tx_done && (cnt == TO_LAST);

   assign trmt = launch;

   resp_slot u_cc_slot (
      .clk      (clk),
      .rst      (rst),
      .req      (cc_req),
      .req_dat  (cc_data),
      .req_last (1'b0),
      .clr      (cc_clr),
      .pend     (cc_pend),
      .dat      (cc_dat),
      .last     (cc_last),
      .ovf      (cc_ovf)
   );

   resp_slot u_ram_slot (
      .clk      (clk),
      .rst      (rst),
      .req      (ram_req),
      .req_dat  (ram_data),
      .req_last (ram_last),
      .clr      (ram_clr),
      .pend     (ram_pend),
      .dat      (ram_dat),
      .last     (ram_last_q),
      .ovf      (ram_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         own      <= OWN_CC;
         lock     <= 1'b0;
         cur_last <= 1'b0;
         cnt      <= '0;
         tx_data  <= 8'h00;
         cc_done  <= 1'b0;
         ram_done <= 1'b0;
         ovf_err  <= 1'b0;
         to_err   <= 1'b0;
      end else begin
         cc_done  <= done_fire && (own == OWN_CC);
         ram_done <= done_fire && (own == OWN_RAM);
         ovf_err  <= (ovf_err && !err_clr) || cc_ovf || ram_ovf;
         to_err   <= (to_err && !err_clr) || to_fire;

         case (state)
            IDLE: begin
               if (pick_cc) begin
                  own      <= OWN_CC;
                  tx_data  <= cc_dat;
                  cur_last <= cc_last;
                  state    <= LAUNCH;
               end else if (pick_ram) begin
                  own      <= OWN_RAM;
                  tx_data  <= ram_dat;
                  cur_last <= ram_last_q;
                  state    <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt <= '0;
               if (own == OWN_RAM) begin
                  lock <= !cur_last;
               end
               state <= WAIT;
            end
            WAIT: begin
               if (done_fire) begin
                  if ((own == OWN_RAM) && cur_last) begin
                     lock <= 1'b0;
                  end
                  state <= IDLE;
               end else if (to_fire) begin
                  // Abandon the byte silently; the other slot keeps its contents.
                  lock  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_resp_arb.sv
// Bench for resp_arb: vector table, directed corner sequences, and random traffic against a timestamp model.
module tb_resp_arb;

   localparam int TO = 16;

   logic       clk;
   logic       rst;
   logic       cc_req;
   logic [7:0] cc_data;
   logic       cc_done;
   logic       ram_req;
   logic [7:0] ram_data;
   logic       ram_last;
   logic       ram_done;
   logic       trmt;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       ovf_err;
   logic       to_err;
   logic       err_clr;

   resp_arb #(.TO_CYC(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .cc_req   (cc_req),
      .cc_data  (cc_data),
      .cc_done  (cc_done),
      .ram_req  (ram_req),
      .ram_data (ram_data),
      .ram_last (ram_last),
      .ram_done (ram_done),
      .trmt     (trmt),
      .tx_data  (tx_data),
      .tx_done  (tx_done),
      .ovf_err  (ovf_err),
      .to_err   (to_err),
      .err_clr  (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n_cmp;
   int n_bad;
   int cyc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: a launched byte owns the channel from cycle m_L; completion or timeout
   // is judged from timestamps relative to m_L, pending bytes sit in one-entry slots.
   bit         m_pend [2];
   logic [7:0] m_dat  [2];
   bit         m_last [2];
   bit         m_lock, m_busy, m_own, m_cur_last;
   int         m_L;
   logic [7:0] m_txd;
   bit         m_ccd, m_rd, m_ovf, m_to;

   task automatic model_step(input bit cr, input logic [7:0] cd, input bit rr, input logic [7:0] rd,
                             input bit rl, input bit td, input bit clr, input bit rs);
      bit req [2];
      logic [7:0] d [2];
      bit l [2];
      bit busy0, own0, to_ev, ovf_ev, clear_p;
      int L0, n, p;
      n = cyc;
      if (rs) begin
         for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_dat[i] = 8'h00; m_last[i] = 0;
         end
         m_lock = 0; m_busy = 0; m_own = 0; m_cur_last = 0; m_L = 0;
         m_txd = 8'h00; m_ccd = 0; m_rd = 0; m_ovf = 0; m_to = 0;
         return;
      end
      req[0] = cr; d[0] = cd; l[0] = 0;
      req[1] = rr; d[1] = rd; l[1] = rl;
      busy0 = m_busy; L0 = m_L; own0 = m_own;
      m_ccd = 0; m_rd = 0; to_ev = 0; ovf_ev = 0;
      if (busy0 && n > L0) begin
         if (td) begin
            if (own0) m_rd = 1; else m_ccd = 1;
            m_busy = 0;
            if (own0 && m_cur_last) m_lock = 0;
         end else if (n == L0 + TO) begin
            to_ev = 1; m_busy = 0; m_lock = 0;
         end
      end
      if (busy0 && n == L0 && own0) m_lock = !m_cur_last;
      if (!busy0) begin
         p = -1;
         if (m_lock) begin
            if (m_pend[1]) p = 1;
         end else if (m_pend[0]) p = 0;
         else if (m_pend[1]) p = 1;
         if (p >= 0) begin
            m_busy = 1; m_L = n + 1; m_own = (p == 1);
            m_txd = m_dat[p]; m_cur_last = m_last[p];
         end
      end
      for (int i = 0; i < 2; i++) begin
         clear_p = busy0 && (n == L0) && (own0 == (i == 1));
         if (req[i] && (!m_pend[i] || clear_p)) begin
            m_pend[i] = 1; m_dat[i] = d[i]; m_last[i] = l[i];
         end else if (req[i]) ovf_ev = 1;
         else if (clear_p) m_pend[i] = 0;
      end
      m_ovf = (m_ovf && !clr) || ovf_ev;
      m_to  = (m_to && !clr) || to_ev;
   endtask

   task automatic cyc_step(input bit cr, input logic [7:0] cd, input bit rr, input logic [7:0] rd,
                           input bit rl, input bit td, input bit clr, input bit rs);
      cc_req = cr; cc_data = cd; ram_req = rr; ram_data = rd; ram_last = rl;
      tx_done = td; err_clr = clr; rst = rs;
      model_step(cr, cd, rr, rd, rl, td, clr, rs);
      @(posedge clk);
      #1;
      cyc++;
      chk("model_trmt",     32'(trmt),     32'(m_busy && m_L == cyc));
      chk("model_tx_data",  32'(tx_data),  32'(m_txd));
      chk("model_cc_done",  32'(cc_done),  32'(m_ccd));
      chk("model_ram_done", 32'(ram_done), 32'(m_rd));
      chk("model_ovf_err",  32'(ovf_err),  32'(m_ovf));
      chk("model_to_err",   32'(to_err),   32'(m_to));
   endtask

   // Directed-sequence helpers: optional auto tx_done responder and a log of launched bytes.
   int         resp_dly, age, last_td_cyc, n_ccd, n_rd;
   logic [7:0] sent [$];
   int         gaps [$];

   task automatic drive(input bit cr, input logic [7:0] cd, input bit rr, input logic [7:0] rd,
                        input bit rl, input bit clr, input bit rs);
      bit td;
      td = (resp_dly > 0) && (age == resp_dly);
      if (td) last_td_cyc = cyc;
      cyc_step(cr, cd, rr, rd, rl, td, clr, rs);
      if (trmt) begin
         age = 0;
         sent.push_back(tx_data);
         gaps.push_back(cyc - last_td_cyc);
      end else begin
         age++;
      end
      n_ccd += int'(cc_done);
      n_rd  += int'(ram_done);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 8'h00, 0, 8'h00, 0, 0, 0);
   endtask

   task automatic do_reset();
      drive(0, 8'h00, 0, 8'h00, 0, 0, 1);
      drive(0, 8'h00, 0, 8'h00, 0, 0, 1);
      sent.delete(); gaps.delete();
      n_ccd = 0; n_rd = 0; age = 1000; last_td_cyc = 0;
   endtask

   typedef struct {
      bit cr; logic [7:0] cd; bit rr; logic [7:0] rd; bit rl; bit td; bit clr;
      bit e_trmt; logic [7:0] e_txd; bit e_ccd; bit e_rd; bit e_ovf;
   } vec_t;
   vec_t vecs [$];

   task automatic add(input bit cr, input logic [7:0] cd, input bit rr, input logic [7:0] rd,
                      input bit rl, input bit td, input bit clr,
                      input bit e_trmt, input logic [7:0] e_txd, input bit e_ccd, input bit e_rd, input bit e_ovf);
      vec_t v;
      v.cr = cr; v.cd = cd; v.rr = rr; v.rd = rd; v.rl = rl; v.td = td; v.clr = clr;
      v.e_trmt = e_trmt; v.e_txd = e_txd; v.e_ccd = e_ccd; v.e_rd = e_rd; v.e_ovf = e_ovf;
      vecs.push_back(v);
   endtask

   int t_to, t_r;
   logic [7:0] exp_order [4];

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; resp_dly = 0;
      cc_req = 0; cc_data = 0; ram_req = 0; ram_data = 0; ram_last = 0;
      tx_done = 0; err_clr = 0; rst = 1;

      do_reset();
      chk("rst_trmt",     32'(trmt),     32'd0);
      chk("rst_tx_data",  32'(tx_data),  32'h00);
      chk("rst_cc_done",  32'(cc_done),  32'd0);
      chk("rst_ram_done", 32'(ram_done), 32'd0);
      chk("rst_ovf_err",  32'(ovf_err),  32'd0);
      chk("rst_to_err",   32'(to_err),   32'd0);

      // Single cc byte (tx_done 10 cycles after trmt), then overflow with err_clr.
      add(1, 8'hA5, 0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 0, 0,  1, 8'hA5, 0, 0, 0);
      for (int i = 0; i < 10; i++) add(0, 8'h00, 0, 8'h00, 0, 0, 0,  0, 8'hA5, 0, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 1, 0,  0, 8'hA5, 1, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 0, 0,  0, 8'hA5, 0, 0, 0);
      add(0, 8'h00, 1, 8'h33, 1, 0, 0,  0, 8'hA5, 0, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 0, 0,  1, 8'h33, 0, 0, 0);
      add(1, 8'h10, 0, 8'h00, 0, 0, 0,  0, 8'h33, 0, 0, 0);
      add(1, 8'h20, 0, 8'h00, 0, 0, 0,  0, 8'h33, 0, 0, 1);
      add(0, 8'h00, 0, 8'h00, 0, 1, 0,  0, 8'h33, 0, 1, 1);
      add(0, 8'h00, 0, 8'h00, 0, 0, 0,  1, 8'h10, 0, 0, 1);
      add(0, 8'h00, 0, 8'h00, 0, 1, 0,  0, 8'h10, 0, 0, 1);
      add(0, 8'h00, 0, 8'h00, 0, 0, 1,  0, 8'h10, 0, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 1, 0,  0, 8'h10, 1, 0, 0);
      add(0, 8'h00, 0, 8'h00, 0, 0, 0,  0, 8'h10, 0, 0, 0);
      foreach (vecs[i]) begin
         cyc_step(vecs[i].cr, vecs[i].cd, vecs[i].rr, vecs[i].rd, vecs[i].rl, vecs[i].td, vecs[i].clr, 0);
         chk($sformatf("vec%0d_trmt", i),     32'(trmt),     32'(vecs[i].e_trmt));
         chk($sformatf("vec%0d_tx_data", i),  32'(tx_data),  32'(vecs[i].e_txd));
         chk($sformatf("vec%0d_cc_done", i),  32'(cc_done),  32'(vecs[i].e_ccd));
         chk($sformatf("vec%0d_ram_done", i), 32'(ram_done), 32'(vecs[i].e_rd));
         chk($sformatf("vec%0d_ovf_err", i),  32'(ovf_err),  32'(vecs[i].e_ovf));
         chk($sformatf("vec%0d_to_err", i),   32'(to_err),   32'd0);
      end

      // Simultaneous reqs: cc first, ram two cycles after cc's tx_done.
      do_reset();
      resp_dly = 5;
      drive(1, 8'h06, 1, 8'h11, 0, 0, 0);
      for (int k = 0; k < 40 && sent.size() < 2; k++) idle(1);
      idle(8);
      chk("sim_count", sent.size(), 2);
      if (sent.size() >= 2) begin
         chk("sim_first",   32'(sent[0]), 32'h06);
         chk("sim_second",  32'(sent[1]), 32'h11);
         chk("sim_ram_gap", gaps[1], 2);
      end
      chk("sim_cc_done_cnt",  n_ccd, 1);
      chk("sim_ram_done_cnt", n_rd, 1);

      // Dump lock: cc byte waits for the whole burst.
      do_reset();
      resp_dly = 4;
      for (int k = 0; k < 40; k++)
         drive(k == 3, 8'h05, (k == 0) || (k == 4) || (k == 9),
               (k == 0) ? 8'h01 : ((k == 4) ? 8'h02 : 8'h03), k == 9, 0, 0);
      exp_order[0] = 8'h01; exp_order[1] = 8'h02; exp_order[2] = 8'h03; exp_order[3] = 8'h05;
      chk("lock_count", sent.size(), 4);
      for (int i = 0; i < 4 && i < sent.size(); i++)
         chk($sformatf("lock_order%0d", i), 32'(sent[i]), 32'(exp_order[i]));

      // Timeout: no tx_done for the cc byte, pending ram byte follows.
      do_reset();
      resp_dly = 0;
      t_to = -1; t_r = -1;
      for (int k = 0; k < 26; k++) begin
         drive(k == 0, 8'h77, k == 5, 8'h44, 1, 0, 0);
         if (to_err && t_to < 0) t_to = k + 1;
         if (trmt && tx_data == 8'h44 && t_r < 0) t_r = k + 1;
      end
      chk("to_cycle",      t_to, 19);
      chk("to_no_cc_done", n_ccd, 0);
      chk("to_ram_launch", t_r, 20);
      drive(0, 8'h00, 0, 8'h00, 0, 1, 0);
      chk("to_err_clr", 32'(to_err), 32'd0);

      // Reset during WAIT of ram byte 02, then a cc byte is served at once.
      do_reset();
      resp_dly = 4;
      for (int k = 0; k < 10; k++)
         drive(0, 8'h00, (k == 0) || (k == 4), (k == 0) ? 8'h01 : 8'h02, 0, 0, 0);
      chk("mid_sent_cnt", sent.size(), 2);
      drive(0, 8'h00, 0, 8'h00, 0, 0, 1);
      chk("mid_rst_trmt",     32'(trmt),     32'd0);
      chk("mid_rst_tx_data",  32'(tx_data),  32'h00);
      chk("mid_rst_ram_done", 32'(ram_done), 32'd0);
      chk("mid_rst_cc_done",  32'(cc_done),  32'd0);
      drive(1, 8'h5A, 0, 8'h00, 0, 0, 0);
      drive(0, 8'h00, 0, 8'h00, 0, 0, 0);
      chk("mid_cc_trmt",    32'(trmt),    32'd1);
      chk("mid_cc_tx_data", 32'(tx_data), 32'h5A);
      idle(10);

      // Random traffic, including spurious/withheld tx_done, err_clr and rare resets.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         bit cr, rr, rl, td, clr, rs;
         cr  = ($urandom_range(0, 5) == 0);
         rr  = ($urandom_range(0, 5) == 0);
         rl  = ($urandom_range(0, 2) == 0);
         td  = ($urandom_range(0, 5) == 0);
         clr = ($urandom_range(0, 19) == 0);
         rs  = ($urandom_range(0, 399) == 0);
         cyc_step(cr, 8'($urandom), rr, 8'($urandom), rl, td, clr, rs);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
